// File: rtl/mem_arbiter_pkg.sv
// Shared constants and helpers for the two-port data-memory arbiter.
package mem_arbiter_pkg;

  localparam int PORT_CORE   = 0;
  localparam int PORT_DBG    = 1;
  localparam int BURST_CNT_W = 4;

  typedef enum logic [1:0] {
    SEL_NONE = 2'b00,
    SEL_CORE = 2'b01,
    SEL_DBG  = 2'b10
  } arb_sel_e;

  // One-hot port whose read is being granted; writes never return data.
  function automatic logic [1:0] rd_pend_next(input logic [1:0] gnt, input logic [1:0] we);
    return gnt & ~we;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Per-requester handshake bundle: request/command in, grant and read return out.
interface mem_arbiter_if #(parameter int WIDTH = 32) ();

  logic             req;
  logic             we;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic             gnt;
  logic             rvalid;
  logic [WIDTH-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/arb2_burst.sv
// Two-way priority arbiter: port 0 preferred, port 1 forced in after MAX_BURST waits.
module arb2_burst
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  localparam logic [BURST_CNT_W-1:0] MAX_CNT = BURST_CNT_W'(MAX_BURST);

  logic [BURST_CNT_W-1:0] burst_cnt_q;
  logic [BURST_CNT_W-1:0] burst_cnt_d;
  arb_sel_e               sel_s;

  // Grant selection; held off entirely while reset is asserted.
  always_comb begin
    sel_s = SEL_NONE;
    if (!rst_n) begin
      sel_s = SEL_NONE;
    end else begin
      case (req_i)
        2'b01:   sel_s = SEL_CORE;
        2'b10:   sel_s = SEL_DBG;
        2'b11:   sel_s = (burst_cnt_q == MAX_CNT) ? SEL_DBG : SEL_CORE;
        default: sel_s = SEL_NONE;
      endcase
    end
  end

  assign gnt_o[PORT_CORE] = (sel_s == SEL_CORE);
  assign gnt_o[PORT_DBG]  = (sel_s == SEL_DBG);

  // Counts core grants taken while the debug port waits; saturates at MAX_CNT.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (!req_i[PORT_DBG] || (sel_s == SEL_DBG)) begin
      burst_cnt_d = {BURST_CNT_W{1'b0}};
    end else if ((sel_s == SEL_CORE) && (burst_cnt_q != MAX_CNT)) begin
      burst_cnt_d = burst_cnt_q + {{(BURST_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      burst_cnt_d = burst_cnt_q;
    end
  end

  // Burst counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt_q <= {BURST_CNT_W{1'b0}};
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port data memory between the core (port 0) and loader/debug (port 1).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_arbiter_if.slave     p0,
  mem_arbiter_if.slave     p1,
  output logic [WIDTH-1:0] mem_address_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  input  logic [WIDTH-1:0] mem_rdata_i
);

  logic [1:0] req_s;
  logic [1:0] we_s;
  logic [1:0] gnt_s;
  logic [1:0] rd_pend_q;
  logic [1:0] rd_pend_d;

  assign req_s = {p1.req, p0.req};
  assign we_s  = {p1.we,  p0.we};

  arb2_burst #(.MAX_BURST(MAX_BURST)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req_s),
    .gnt_o (gnt_s)
  );

  // Route the granted port onto the memory bus; the bus idles at zero.
  always_comb begin
    mem_address_o = {WIDTH{1'b0}};
    mem_wdata_o   = {WIDTH{1'b0}};
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    case (gnt_s)
      2'b01: begin
        mem_address_o = p0.addr;
        mem_wdata_o   = p0.wdata;
        mem_read_o    = ~p0.we;
        mem_write_o   = p0.we;
      end
      2'b10: begin
        mem_address_o = p1.addr;
        mem_wdata_o   = p1.wdata;
        mem_read_o    = ~p1.we;
        mem_write_o   = p1.we;
      end
      default: begin
        mem_address_o = {WIDTH{1'b0}};
        mem_wdata_o   = {WIDTH{1'b0}};
        mem_read_o    = 1'b0;
        mem_write_o   = 1'b0;
      end
    endcase
  end

  assign rd_pend_d = rd_pend_next(gnt_s, we_s);

  // Remembers which port owns the read data MEM returns next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q <= 2'b00;
    end else begin
      rd_pend_q <= rd_pend_d;
    end
  end

  assign p0.gnt    = gnt_s[PORT_CORE];
  assign p1.gnt    = gnt_s[PORT_DBG];
  assign p0.rvalid = rd_pend_q[PORT_CORE];
  assign p1.rvalid = rd_pend_q[PORT_DBG];
  assign p0.rdata  = rd_pend_q[PORT_CORE] ? mem_rdata_i : {WIDTH{1'b0}};
  assign p1.rdata  = rd_pend_q[PORT_DBG]  ? mem_rdata_i : {WIDTH{1'b0}};

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int W  = 32;
  localparam int MB = 4;
  localparam int VW = 4 + 2*W + 2 + 2*W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] mem_address, mem_wdata;
  logic [W-1:0] mem_rdata = '0;
  logic         mem_read, mem_write;

  always #5 clk = ~clk;

  mem_arbiter_if #(.WIDTH(W)) p0_if ();
  mem_arbiter_if #(.WIDTH(W)) p1_if ();

  mem_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .p0            (p0_if),
    .p1            (p1_if),
    .mem_address_o (mem_address),
    .mem_wdata_o   (mem_wdata),
    .mem_read_o    (mem_read),
    .mem_write_o   (mem_write),
    .mem_rdata_i   (mem_rdata)
  );

  // Registered-output memory on the bus, 16 words deep.
  logic [W-1:0] mem_arr [0:15];
  always @(posedge clk) begin
    if (mem_write) mem_arr[mem_address[3:0]] <= mem_wdata;
    mem_rdata <= mem_read ? mem_arr[mem_address[3:0]] : '0;
  end

  // Reference model: memory image, outstanding reads, p0 grants since p1 began waiting.
  logic [W-1:0] ref_mem [0:15];
  logic         pend0, pend1;
  logic [W-1:0] pdat0, pdat1;
  int           streak;
  logic         eg0, eg1;
  logic [VW-1:0] obs_v, exp_v;
  logic         o_g0, o_g1, o_mr, o_mw, o_rv0, o_rv1;
  logic [W-1:0] o_rd0, o_rd1;
  int           n_cmp = 0;
  int           n_bad = 0;

  function automatic logic [VW-1:0] pack_obs();
    return {p1_if.gnt, p0_if.gnt, mem_read, mem_write, mem_address, mem_wdata,
            p1_if.rvalid, p0_if.rvalid, p1_if.rdata, p0_if.rdata};
  endfunction

  task automatic drv0(input logic rq, input logic we, input logic [W-1:0] a, input logic [W-1:0] d);
    p0_if.req = rq; p0_if.we = we; p0_if.addr = a; p0_if.wdata = d;
  endtask

  task automatic drv1(input logic rq, input logic we, input logic [W-1:0] a, input logic [W-1:0] d);
    p1_if.req = rq; p1_if.we = we; p1_if.addr = a; p1_if.wdata = d;
  endtask

  // One clock: predict, sample at negedge, then advance the model past the posedge.
  task automatic step();
    logic r0, r1, w0, w1, er, ew;
    logic [W-1:0] a0, a1, d0, d1, ea, ed, x0, x1;
    @(negedge clk);
    r0 = p0_if.req; r1 = p1_if.req; w0 = p0_if.we; w1 = p1_if.we;
    a0 = p0_if.addr; a1 = p1_if.addr; d0 = p0_if.wdata; d1 = p1_if.wdata;
    if (!rst_n) begin eg0 = 1'b0; eg1 = 1'b0; end
    else if (r0 && r1) begin eg1 = (streak >= MB); eg0 = !eg1; end
    else begin eg0 = r0; eg1 = r1; end
    ea = '0; ed = '0; er = 1'b0; ew = 1'b0;
    if (eg0) begin ea = a0; ed = d0; er = !w0; ew = w0; end
    if (eg1) begin ea = a1; ed = d1; er = !w1; ew = w1; end
    x0 = pend0 ? pdat0 : '0;
    x1 = pend1 ? pdat1 : '0;
    exp_v = {eg1, eg0, er, ew, ea, ed, pend1, pend0, x1, x0};
    obs_v = pack_obs();
    {o_g1, o_g0, o_mr, o_mw} = obs_v[VW-1 -: 4];
    o_rv1 = p1_if.rvalid; o_rv0 = p0_if.rvalid; o_rd1 = p1_if.rdata; o_rd0 = p0_if.rdata;
    @(posedge clk); #1;
    pend0 = 1'b0; pend1 = 1'b0;
    if (!rst_n) begin
      streak = 0;
    end else begin
      if (eg0 && w0) ref_mem[a0[3:0]] = d0;
      if (eg0 && !w0) begin pend0 = 1'b1; pdat0 = ref_mem[a0[3:0]]; end
      if (eg1 && w1) ref_mem[a1[3:0]] = d1;
      if (eg1 && !w1) begin pend1 = 1'b1; pdat1 = ref_mem[a1[3:0]]; end
      if (!r1 || eg1) streak = 0;
      else if (eg0) streak = streak + 1;
    end
  endtask

  task automatic test_reset();
    drv0(1'b1, 1'b0, 32'd1, 32'd0);
    drv1(1'b1, 1'b1, 32'd2, 32'h55);
    #2;
    n_cmp++;
    if (pack_obs() !== {VW{1'b0}}) begin
      n_bad++; $display("FAIL reset_outputs got=%h want=0", pack_obs());
    end
    step();
    n_cmp++;
    if (obs_v !== exp_v) begin n_bad++; $display("FAIL reset_step got=%h want=%h", obs_v, exp_v); end
    rst_n = 1'b1;
    drv0(1'b0, 1'b0, '0, '0);
    drv1(1'b0, 1'b0, '0, '0);
    step();
  endtask

  task automatic test_write_read();
    drv0(1'b1, 1'b1, 32'd5, 32'hDEADBEEF);
    step();
    n_cmp++;
    if (o_mw !== 1'b1 || o_g0 !== 1'b1) begin
      n_bad++; $display("FAIL wr_grant got gnt=%b mem_write=%b want 1,1", o_g0, o_mw);
    end
    drv0(1'b1, 1'b0, 32'd5, 32'd0);
    step();
    n_cmp++;
    if (obs_v !== exp_v) begin n_bad++; $display("FAIL rd_grant got=%h want=%h", obs_v, exp_v); end
    drv0(1'b0, 1'b0, '0, '0);
    step();
    n_cmp++;
    if (o_rv0 !== 1'b1 || o_rd0 !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL rd_data got rvalid=%b rdata=%h want 1 deadbeef", o_rv0, o_rd0);
    end
  endtask

  task automatic test_p1_stream();
    int g1 = 0, rv1 = 0, rv0 = 0;
    for (int i = 0; i < 4; i++) begin
      drv1(1'b1, 1'b1, i, $urandom);
      step();
    end
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drv1(1'b1, 1'b0, i, '0); else drv1(1'b0, 1'b0, '0, '0);
      step();
      n_cmp++;
      if (obs_v !== exp_v) begin n_bad++; $display("FAIL p1_stream[%0d] got=%h want=%h", i, obs_v, exp_v); end
      if (o_g1 === 1'b1) g1++;
      if (o_rv1 === 1'b1 && i > 0) rv1++;
      if (o_rv0 !== 1'b0) rv0++;
    end
    n_cmp++;
    if (g1 != 4 || rv1 != 4 || rv0 != 0) begin
      n_bad++; $display("FAIL p1_stream_counts got gnt=%0d rvalid=%0d p0_rvalid=%0d want 4 4 0", g1, rv1, rv0);
    end
  endtask

  task automatic test_burst();
    for (int k = 0; k < 12; k++) begin
      drv0(1'b1, 1'b0, $urandom_range(0, 15), '0);
      drv1(1'b1, 1'b0, $urandom_range(0, 15), '0);
      step();
      n_cmp++;
      if (o_g1 !== ((k % 5) == 4) || o_g0 !== ((k % 5) != 4) || obs_v !== exp_v) begin
        n_bad++; $display("FAIL burst_order[%0d] got g0=%b g1=%b want g1=%0d", k, o_g0, o_g1, (k % 5) == 4);
      end
    end
    drv0(1'b0, 1'b0, '0, '0);
    drv1(1'b0, 1'b0, '0, '0);
    step();
  endtask

  task automatic test_same_cycle();
    drv0(1'b1, 1'b1, 32'd7, 32'h11);
    step();
    drv0(1'b1, 1'b0, 32'd7, '0);
    drv1(1'b1, 1'b1, 32'd7, 32'h22);
    step();
    n_cmp++;
    if (o_g0 !== 1'b1 || o_g1 !== 1'b0) begin n_bad++; $display("FAIL same_first got g0=%b g1=%b want 1 0", o_g0, o_g1); end
    drv0(1'b0, 1'b0, '0, '0);
    step();
    n_cmp++;
    if (o_g1 !== 1'b1 || o_mw !== 1'b1 || o_rv0 !== 1'b1 || o_rd0 !== 32'h11) begin
      n_bad++; $display("FAIL same_second got g1=%b mw=%b rv0=%b rd0=%h want 1 1 1 11", o_g1, o_mw, o_rv0, o_rd0);
    end
    drv1(1'b0, 1'b0, '0, '0);
    drv0(1'b1, 1'b0, 32'd7, '0);
    step();
    drv0(1'b0, 1'b0, '0, '0);
    step();
    n_cmp++;
    if (o_rv0 !== 1'b1 || o_rd0 !== 32'h22) begin
      n_bad++; $display("FAIL same_readback got rv=%b rd=%h want 1 22", o_rv0, o_rd0);
    end
  endtask

  task automatic test_reset_mid_burst();
    for (int k = 0; k < 3; k++) begin
      drv0(1'b1, 1'b0, k, '0);
      drv1(1'b1, 1'b0, 32'd9, '0);
      step();
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (pack_obs() !== {VW{1'b0}}) begin n_bad++; $display("FAIL async_reset got=%h want=0", pack_obs()); end
    pend0 = 1'b0; pend1 = 1'b0; streak = 0;
    step();
    n_cmp++;
    if (obs_v !== exp_v) begin n_bad++; $display("FAIL reset_hold got=%h want=%h", obs_v, exp_v); end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      n_cmp++;
      if (o_g1 !== (k == 4) || obs_v !== exp_v) begin
        n_bad++; $display("FAIL post_reset[%0d] got g0=%b g1=%b want g1=%0d", k, o_g0, o_g1, k == 4);
      end
    end
    drv0(1'b0, 1'b0, '0, '0);
    drv1(1'b0, 1'b0, '0, '0);
    step();
  endtask

  task automatic test_p1_drop();
    int bad_g1 = 0, bad_mw = 0;
    for (int k = 0; k < 5; k++) begin
      drv0(1'b1, 1'b0, $urandom_range(0, 15), '0);
      if (k < 2) drv1(1'b1, 1'b1, 32'd3, 32'hBAD0BAD0); else drv1(1'b0, 1'b0, '0, '0);
      step();
      if (o_g1 !== 1'b0) bad_g1++;
      if (o_mw !== 1'b0) bad_mw++;
    end
    n_cmp++;
    if (bad_g1 != 0 || bad_mw != 0) begin
      n_bad++; $display("FAIL p1_drop got p1_gnt_cycles=%0d mem_write_cycles=%0d want 0 0", bad_g1, bad_mw);
    end
    for (int k = 0; k < 5; k++) begin
      drv0(1'b1, 1'b0, $urandom_range(0, 15), '0);
      drv1(1'b1, 1'b0, 32'd3, '0);
      step();
      n_cmp++;
      if (o_g1 !== (k == 4) || obs_v !== exp_v) begin
        n_bad++; $display("FAIL drop_cleared[%0d] got g0=%b g1=%b want g1=%0d", k, o_g0, o_g1, k == 4);
      end
    end
    drv0(1'b0, 1'b0, '0, '0);
    drv1(1'b0, 1'b0, '0, '0);
    step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      if (!p0_if.req && $urandom_range(0, 1) == 1)
        drv0(1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom);
      else if (p0_if.req && $urandom_range(0, 7) == 0)
        p0_if.req = 1'b0;
      if (!p1_if.req && $urandom_range(0, 2) == 0)
        drv1(1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom);
      else if (p1_if.req && $urandom_range(0, 7) == 0)
        p1_if.req = 1'b0;
      step();
      n_cmp++;
      if (obs_v !== exp_v) begin n_bad++; $display("FAIL random[%0d] got=%h want=%h", n, obs_v, exp_v); end
      if (eg0) p0_if.req = 1'b0;
      if (eg1) p1_if.req = 1'b0;
    end
    drv0(1'b0, 1'b0, '0, '0);
    drv1(1'b0, 1'b0, '0, '0);
    step();
    n_cmp++;
    if (obs_v !== exp_v) begin n_bad++; $display("FAIL random_drain got=%h want=%h", obs_v, exp_v); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin mem_arr[i] = '0; ref_mem[i] = '0; end
    pend0 = 1'b0; pend1 = 1'b0; pdat0 = '0; pdat1 = '0; streak = 0;
    drv0(1'b0, 1'b0, '0, '0);
    drv1(1'b0, 1'b0, '0, '0);
    test_reset();
    test_write_read();
    test_p1_stream();
    test_burst();
    test_same_cycle();
    test_reset_mid_burst();
    test_p1_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
